// File: rtl/systolic_array_pkg.sv
// systolic_array_pkg: command, command-record and sequencer-state types shared by the
// matmul command front-end.
package systolic_array_pkg;
  typedef enum logic [1:0] {
    CMD_WRITE  = 2'd0,
    CMD_READ   = 2'd1,
    CMD_MATMUL = 2'd2,
    CMD_RSVD   = 2'd3
  } cmd_op_t;
  typedef struct packed {
    cmd_op_t     op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] x_addr;
    logic [31:0] w_addr;
    logic [31:0] y_addr;
  } sc_cmd_t;
  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    MM_START,
    MM_WAIT_BUSY,
    MM_WAIT_DONE,
    RELEASE
  } seq_state_t;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO with a combinational head; a count register disambiguates
// full from empty.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= din;
  assign dout  = mem_q[rd_q];
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/matmul_cmd_sequencer.sv
// matmul_cmd_sequencer: buffers host commands and executes them one at a time against
// the systolic-array controller scratchpad port and start/stall handshake.
module matmul_cmd_sequencer
  import systolic_array_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [31:0] cmd_x_addr,
  input  logic [31:0] cmd_w_addr,
  input  logic [31:0] cmd_y_addr,
  output logic [31:0] x_addr,
  output logic [31:0] w_addr,
  output logic [31:0] y_addr,
  output logic        start_mul,
  input  logic        stall_mul,
  output logic        controller_sc_read_en,
  output logic        controller_sc_write_en,
  output logic [31:0] controller_sc_addr,
  output logic [31:0] controller_sc_in,
  input  logic [31:0] controller_sc_out,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        mm_done,
  output logic        op_err,
  output logic        busy
);
  localparam int CW = $clog2(RD_LAT + 2);
  sc_cmd_t head, din;
  logic full, empty, pop;
  seq_state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rsp_data_q, rsp_data_d;
  logic [31:0] x_q, x_d, w_q, w_d, y_q, y_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic rsp_valid_q, rsp_valid_d;
  assign din = '{op: cmd_op_t'(cmd_op), addr: cmd_addr, wdata: cmd_wdata,
                 x_addr: cmd_x_addr, w_addr: cmd_w_addr, y_addr: cmd_y_addr};
  cmd_fifo #(.DEPTH(DEPTH), .W($bits(sc_cmd_t))) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (cmd_valid && !full),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_cnt_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      x_q         <= '0;
      w_q         <= '0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_cnt_q    <= rd_cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      x_q         <= x_d;
      w_q         <= w_d;
      y_q         <= y_d;
    end
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_cnt_d    = rd_cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    x_d         = x_q;
    w_d         = w_q;
    y_d         = y_q;
    pop         = 1'b0;
    op_err      = 1'b0;
    start_mul   = 1'b0;
    mm_done     = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop      = 1'b1;
        addr_d   = head.addr;
        wdata_d  = head.wdata;
        rd_cnt_d = '0;
        case (head.op)
          CMD_WRITE: state_d = WR;
          CMD_READ:  state_d = RD;
          CMD_MATMUL: begin
            state_d = MM_START;
            x_d     = head.x_addr;
            w_d     = head.w_addr;
            y_d     = head.y_addr;
          end
          default: op_err = 1'b1;
        endcase
      end
      WR: state_d = RELEASE;
      RD: if (rd_cnt_q == CW'(RD_LAT)) begin
        rsp_data_d  = controller_sc_out;
        rsp_valid_d = 1'b1;
        state_d     = RELEASE;
      end else rd_cnt_d = rd_cnt_q + CW'(1);
      MM_START: if (!stall_mul) begin
        start_mul = 1'b1;
        state_d   = MM_WAIT_BUSY;
      end
      MM_WAIT_BUSY: if (stall_mul) state_d = MM_WAIT_DONE;
      MM_WAIT_DONE: if (!stall_mul) begin
        mm_done = 1'b1;
        state_d = RELEASE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign cmd_ready              = !full;
  assign controller_sc_write_en = state_q == WR;
  assign controller_sc_read_en  = state_q == RD;
  assign controller_sc_addr     = (controller_sc_write_en || controller_sc_read_en) ? addr_q : '0;
  assign controller_sc_in       = controller_sc_write_en ? wdata_q : '0;
  assign rsp_valid              = rsp_valid_q;
  assign rsp_data               = rsp_data_q;
  assign x_addr                 = x_q;
  assign w_addr                 = w_q;
  assign y_addr                 = y_q;
  assign busy                   = state_q != IDLE || !empty;
endmodule

// File: tb/tb_matmul_cmd_sequencer.sv
// tb_matmul_cmd_sequencer: scenario tasks drive commands and queue the events they expect;
// a negedge monitor pops and compares each observed event and checks handshake timing.
module tb_matmul_cmd_sequencer;
  localparam int DEPTH  = 4;
  localparam int RD_LAT = 1;
  typedef struct packed {
    logic [2:0]  k;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } ev_t;
  logic clk, n_rst, cmd_valid, cmd_ready, start_mul, stall_mul;
  logic [1:0] cmd_op;
  logic [31:0] cmd_addr, cmd_wdata, cmd_x_addr, cmd_w_addr, cmd_y_addr;
  logic [31:0] x_addr, w_addr, y_addr, sc_addr, sc_in, sc_out, rsp_data;
  logic re, we, rsp_valid, mm_done, op_err, busy;
  matmul_cmd_sequencer #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk                    (clk),
    .n_rst                  (n_rst),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_op                 (cmd_op),
    .cmd_addr               (cmd_addr),
    .cmd_wdata              (cmd_wdata),
    .cmd_x_addr             (cmd_x_addr),
    .cmd_w_addr             (cmd_w_addr),
    .cmd_y_addr             (cmd_y_addr),
    .x_addr                 (x_addr),
    .w_addr                 (w_addr),
    .y_addr                 (y_addr),
    .start_mul              (start_mul),
    .stall_mul              (stall_mul),
    .controller_sc_read_en  (re),
    .controller_sc_write_en (we),
    .controller_sc_addr     (sc_addr),
    .controller_sc_in       (sc_in),
    .controller_sc_out      (sc_out),
    .rsp_valid              (rsp_valid),
    .rsp_data               (rsp_data),
    .mm_done                (mm_done),
    .op_err                 (op_err),
    .busy                   (busy)
  );
  int n_chk = 0, n_pass = 0;
  int stall_len = 50, scnt;
  ev_t exp_q[$];
  logic [31:0] exp_mem [int];
  logic [31:0] spm [256];
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  // Top-level stand-in: scratchpad and a multiply engine that stalls stall_len cycles.
  assign sc_out = re ? spm[sc_addr[7:0]] : 32'd0;
  always @(posedge clk)
    if (we) spm[sc_addr[7:0]] <= sc_in;
  always @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      stall_mul <= 1'b0;
      scnt      <= 0;
    end else if (start_mul) begin
      stall_mul <= 1'b1;
      scnt      <= stall_len;
    end else if (scnt > 0) begin
      scnt <= scnt - 1;
      if (scnt == 1) stall_mul <= 1'b0;
    end
  initial begin
    int cyc = 0, last_we = -100, last_done = -100, rd_start = 0, rd_len = 0;
    logic prev_we = 0, prev_re = 0, prev_start = 0, prev_stall = 0;
    ev_t obs[$], e;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        last_we = -100; last_done = -100; rd_len = 0;
        prev_we = 0; prev_re = 0; prev_start = 0; prev_stall = 0;
        continue;
      end
      cyc++;
      n_chk++;
      if (int'(start_mul) + int'(re) + int'(we) > 1) $display("FAIL exclusive: start=%b re=%b we=%b, required at most one", start_mul, re, we);
      else n_pass++;
      n_chk++;
      if ((!we && sc_in !== 0) || (!we && !re && sc_addr !== 0)) $display("FAIL idle_outputs: addr=%h in=%h, required 0", sc_addr, sc_in);
      else n_pass++;
      if (re && !prev_re) begin rd_start = cyc; rd_len = 0; end
      if (re) rd_len++;
      obs.delete();
      if (we) begin
        n_chk++;
        if (prev_we || cyc - last_we < 3) $display("FAIL write_spacing: gap=%0d prev_we=%b, required gap>=3", cyc - last_we, prev_we);
        else n_pass++;
        last_we = cyc;
        obs.push_back({3'd0, sc_addr, sc_in, 32'd0});
      end
      if (rsp_valid) begin
        n_chk++;
        if (rd_len != RD_LAT + 1 || cyc != rd_start + RD_LAT + 1) $display("FAIL read_timing: len=%0d delay=%0d, required %0d/%0d", rd_len, cyc - rd_start, RD_LAT + 1, RD_LAT + 1);
        else n_pass++;
        obs.push_back({3'd1, 32'd0, rsp_data, 32'd0});
      end
      if (start_mul) begin
        n_chk++;
        if (stall_mul || prev_start || cyc < last_done + 3) $display("FAIL start_mul: stall=%b prev=%b since_done=%0d, required 0/0/>=3", stall_mul, prev_start, cyc - last_done);
        else n_pass++;
        obs.push_back({3'd2, x_addr, w_addr, y_addr});
      end
      if (mm_done) begin
        n_chk++;
        if (!prev_stall || stall_mul) $display("FAIL mm_done_timing: prev_stall=%b stall=%b, required 1/0", prev_stall, stall_mul);
        else n_pass++;
        last_done = cyc;
        obs.push_back({3'd3, x_addr, w_addr, y_addr});
      end
      if (op_err) obs.push_back({3'd4, 96'd0});
      foreach (obs[i]) begin
        n_chk++;
        if (exp_q.size() == 0) $display("FAIL unexpected_event: got %h, required none", obs[i]);
        else begin
          e = exp_q.pop_front();
          if (obs[i] !== e) $display("FAIL scoreboard: got %h, required %h", obs[i], e);
          else n_pass++;
        end
      end
      prev_we = we; prev_re = re; prev_start = start_mul; prev_stall = stall_mul;
    end
  end
  task automatic push_cmd(input logic [1:0] op, input logic [31:0] a, d, x, w, y);
    cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_x_addr = x; cmd_w_addr = w; cmd_y_addr = y;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) begin
      n_chk++;
      $display("FAIL push_timeout: cmd_ready=%b, required 1", cmd_ready);
    end
    case (op)
      2'd0: begin exp_q.push_back({3'd0, a, d, 32'd0}); exp_mem[int'(a)] = d; end
      2'd1: exp_q.push_back({3'd1, 32'd0, exp_mem[int'(a)], 32'd0});
      2'd2: begin exp_q.push_back({3'd2, x, w, y}); exp_q.push_back({3'd3, x, w, y}); end
      default: exp_q.push_back({3'd4, 96'd0});
    endcase
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  task automatic wait_idle(input int max);
    for (int i = 0; i < max && (busy || exp_q.size() != 0); i++) @(negedge clk);
    n_chk++;
    if (busy || exp_q.size() != 0) $display("FAIL drain: busy=%b pending=%0d, required 0/0", busy, exp_q.size());
    else n_pass++;
  endtask
  task automatic wait_stall;
    for (int i = 0; i < 100 && !stall_mul; i++) @(negedge clk);
    n_chk++;
    if (!stall_mul) $display("FAIL stall_wait: stall_mul=%b, required 1", stall_mul);
    else n_pass++;
  endtask
  task automatic check_reset_outputs(input string tag);
    n_chk++;
    if ({start_mul, re, we, sc_addr, sc_in, rsp_valid, mm_done, op_err, busy, x_addr, w_addr, y_addr, rsp_data} !== '0)
      $display("FAIL %s_outputs: start=%b re=%b we=%b addr=%h rsp=%b/%h done=%b err=%b busy=%b x=%h w=%h y=%h, required all 0",
               tag, start_mul, re, we, sc_addr, rsp_valid, rsp_data, mm_done, op_err, busy, x_addr, w_addr, y_addr);
    else n_pass++;
    n_chk++;
    if (cmd_ready !== 1'b1) $display("FAIL %s_ready: cmd_ready=%b, required 1", tag, cmd_ready);
    else n_pass++;
  endtask
  task automatic test_reset;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("post_reset");
  endtask
  task automatic test_write_read;
    push_cmd(2'd0, 32'h10, 32'hDEADBEEF, 0, 0, 0);
    push_cmd(2'd1, 32'h10, 0, 0, 0, 0);
    wait_idle(50);
    n_chk++;
    if (rsp_data !== 32'hDEADBEEF) $display("FAIL rsp_hold: rsp_data=%h, required deadbeef", rsp_data);
    else n_pass++;
    push_cmd(2'd0, 32'h20, 32'h12345678, 0, 0, 0);
    push_cmd(2'd0, 32'h21, 32'hA5A5_5A5A, 0, 0, 0);
    push_cmd(2'd1, 32'h21, 0, 0, 0, 0);
    push_cmd(2'd1, 32'h20, 0, 0, 0, 0);
    wait_idle(80);
  endtask
  task automatic test_matmul;
    stall_len = 50;
    push_cmd(2'd2, 0, 0, 32'h0, 32'h1000, 32'h2000);
    push_cmd(2'd0, 32'h30, 32'h0BAD_F00D, 0, 0, 0);
    wait_idle(200);
  endtask
  task automatic test_full_fifo;
    stall_len = 50;
    push_cmd(2'd2, 0, 0, 32'h100, 32'h200, 32'h300);
    wait_stall();
    for (int i = 0; i < DEPTH; i++) push_cmd(2'd0, 32'h40 + i, 32'h1111_0000 + i, 0, 0, 0);
    n_chk++;
    if (cmd_ready !== 1'b0) $display("FAIL full_ready: cmd_ready=%b, required 0", cmd_ready);
    else n_pass++;
    cmd_op = 2'd0; cmd_addr = 32'h99; cmd_wdata = 32'hFFFF_FFFF; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_chk++;
    if (cmd_ready !== 1'b0 || !busy) $display("FAIL full_hold: cmd_ready=%b busy=%b, required 0/1", cmd_ready, busy);
    else n_pass++;
    wait_idle(300);
  endtask
  task automatic test_reserved;
    push_cmd(2'd3, 32'h77, 32'h77, 0, 0, 0);
    push_cmd(2'd0, 32'h5, 32'hCAFE_0005, 0, 0, 0);
    push_cmd(2'd1, 32'h5, 0, 0, 0, 0);
    wait_idle(50);
  endtask
  task automatic test_back_to_back;
    stall_len = 10;
    push_cmd(2'd2, 0, 0, 32'hA0, 32'hB0, 32'hC0);
    push_cmd(2'd2, 0, 0, 32'hA1, 32'hB1, 32'hC1);
    push_cmd(2'd0, 32'h60, 32'h6060_6060, 0, 0, 0);
    wait_idle(200);
  endtask
  task automatic test_reset_mid;
    stall_len = 50;
    push_cmd(2'd2, 0, 0, 32'h500, 32'h600, 32'h700);
    wait_stall();
    repeat (3) @(negedge clk);
    push_cmd(2'd0, 32'h70, 32'h7070_7070, 0, 0, 0);
    push_cmd(2'd1, 32'h10, 0, 0, 0, 0);
    n_rst = 1'b0;
    #1;
    exp_q.delete();
    check_reset_outputs("reset_mid");
    @(negedge clk);
    n_rst = 1'b1;
    repeat (30) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || rsp_data !== 0) $display("FAIL reset_flush: busy=%b rsp_data=%h, required 0/0", busy, rsp_data);
    else n_pass++;
  endtask
  initial begin
    n_rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
    cmd_x_addr = '0; cmd_w_addr = '0; cmd_y_addr = '0;
    test_reset();
    test_write_read();
    test_matmul();
    test_full_fifo();
    test_reserved();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
